// File: rtl/reg_wr_arbiter.sv
// Register file write-port arbiter: processor writeback has strict priority,
// APU results are buffered in a small FIFO and drained in idle cycles.
module reg_wr_arbiter #(
  parameter int data_width    = 32,
  parameter int reg_sel_width = 5,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_wr_req,
  input  logic [reg_sel_width-1:0] proc_wr_sel,
  input  logic [data_width-1:0]    proc_wr_data,
  input  logic                     apu_wr_req,
  input  logic [reg_sel_width-1:0] apu_wr_sel,
  input  logic [data_width-1:0]    apu_wr_data,
  output logic                     apu_ack,
  output logic                     rf_wr_req,
  output logic [reg_sel_width-1:0] rf_wr_sel,
  output logic [data_width-1:0]    rf_wr_data,
  input  logic [reg_sel_width-1:0] chk_sel,
  output logic                     chk_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [reg_sel_width-1:0] fifo_sel  [DEPTH];
  logic [data_width-1:0]    fifo_data [DEPTH];
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         wr_ptr;
  logic [CNT_W-1:0]         count;
  logic                     enq;
  logic                     deq;

  // No pass-through when full: ack depends only on registered count.
  assign apu_ack = apu_wr_req && !rst && (count < CNT_W'(DEPTH));
  assign enq     = apu_wr_req && apu_ack;
  assign deq     = !proc_wr_req && (count != '0);

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_sel[wr_ptr]  <= apu_wr_sel;
      fifo_data[wr_ptr] <= apu_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rf_wr_req  <= 1'b0;
      rf_wr_sel  <= '0;
      rf_wr_data <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      if (proc_wr_req) begin
        rf_wr_req  <= (proc_wr_sel != '0);
        rf_wr_sel  <= proc_wr_sel;
        rf_wr_data <= proc_wr_data;
      end else if (count != '0) begin
        rf_wr_req  <= (fifo_sel[rd_ptr] != '0);
        rf_wr_sel  <= fifo_sel[rd_ptr];
        rf_wr_data <= fifo_data[rd_ptr];
        rd_ptr     <= rd_ptr + PTR_W'(1);
      end else begin
        rf_wr_req <= 1'b0;
      end

      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Walk the occupied slots starting at the head; slot k is valid when k < count.
  logic             hit;
  logic [PTR_W-1:0] idx;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (fifo_sel[idx] == chk_sel)) begin
        hit = 1'b1;
      end
    end
    if (rf_wr_req && (rf_wr_sel == chk_sel)) begin
      hit = 1'b1;
    end
    chk_pending = (chk_sel != '0) && hit;
  end

endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
Single-write-port arbiter between the processor writeback path and the APU result path, feeding the register file write port. APU results are buffered in a small FIFO and acked on enqueue, so the APU never blocks on processor writeback traffic. The block also reports whether a queried register has an APU write still in flight, so the issue logic can stall reads of that register.

Parameters:
data_width, 32, register data width
reg_sel_width, 5, register index width
DEPTH, 4, APU result FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
proc_wr_req  input  1  processor writeback valid (single-cycle, never stalled)
proc_wr_sel  input  reg_sel_width  processor destination register
proc_wr_data  input  data_width  processor writeback data
apu_wr_req  input  1  APU result valid; held with sel/data until acked
apu_wr_sel  input  reg_sel_width  APU destination register
apu_wr_data  input  data_width  APU result data
apu_ack  output  1  APU result accepted this cycle
rf_wr_req  output  1  register file write enable (registered)
rf_wr_sel  output  reg_sel_width  register file write index (registered)
rf_wr_data  output  data_width  register file write data (registered)
chk_sel  input  reg_sel_width  register index queried by issue logic
chk_pending  output  1  chk_sel has a queued or outgoing APU write

Behaviour:
- Reset (rst high at a clk edge): FIFO count, rd_ptr, wr_ptr -> 0; rf_wr_req/sel/data -> 0. apu_ack forced 0 while rst is high. All queued entries are discarded, including mid-stream.
- apu_ack = apu_wr_req && !rst && (count < DEPTH). This is combinational from registered count. A transfer occurs on any clock edge where apu_wr_req && apu_ack; the entry {sel,data} is written at wr_ptr, wr_ptr++.
- Full: count == DEPTH -> apu_ack = 0, even if a dequeue happens the same cycle (no pass-through when full).
- Output stage (every edge, not in reset):
  - if proc_wr_req: rf_wr_req <= (proc_wr_sel != 0), rf_wr_sel/data <= proc. FIFO is not dequeued.
  - else if count > 0: rf_wr_req <= (head.sel != 0), rf_wr_sel/data <= head, rd_ptr++.
  - else: rf_wr_req <= 0 (sel/data hold their previous values).
- Processor has strict priority; APU entries drain only in cycles with no processor write. Entries drain in FIFO order.
- Simultaneous enqueue and dequeue in one cycle: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Latency:
  - Processor write at edge N: visible on rf_wr_* after edge N.
  - APU acked at edge N, FIFO otherwise empty, no processor write in the following cycle: on rf_wr_* after edge N+1 (2 cycles).
- Register 0 writes are accepted/acked and consume a slot and a drain cycle, but never assert rf_wr_req.
- chk_pending (combinational) = chk_sel != 0 && (any valid FIFO entry has sel == chk_sel, OR (rf_wr_req && rf_wr_sel == chk_sel)). The accepting-this-cycle APU input is not included.
- Write ordering between a processor write and a queued APU write to the same register is enforced upstream via chk_pending. The block does no reordering or cancellation.
- Unknown/X inputs on unused cycles (sel/data with req low) must not affect state.

Test Plan:
- Reset then idle -> apu_ack=0, rf_wr_req=0, chk_pending=0 for all chk_sel; assert rst mid-queue with 3 entries -> next cycle count 0, rf_wr_req=0, and nothing drains afterwards.
- APU sel=11 data=23, no processor traffic -> apu_ack high in cycle 0, rf_wr_req=1 sel=11 data=23 after 2nd edge; chk_sel=11 gives chk_pending=1 until the cycle after the rf write, then 0.
- Processor writes every cycle for 6 cycles while APU offers 5 results (sel 1..5) -> first 4 acked, 5th held without ack until a slot frees; after the processor stops, rf writes sel 1,2,3,4,5 in order on consecutive cycles.
- Processor sel=7 data=321 and APU sel=9 data=55 in the same cycle -> rf gets 7/321 next cycle, then 9/55 the cycle after.
- APU and processor writes with sel=0 -> apu_ack=1 but rf_wr_req stays 0; chk_sel=0 gives chk_pending=0 throughout.
- Fill to DEPTH with one drain per cycle over 3×DEPTH transfers (pointer wrap) -> data order preserved and count never exceeds DEPTH.
